rgb_to_hsv: RTL

Iterative RGB-to-HSV converter, the inverse of the colour path's HSV-to-RGB stage. Accepts one 8-bit-per-channel RGB pixel through a valid/ready handshake and returns 8-bit H, S and V through a second valid/ready handshake. H uses the same encoding the HSV-to-RGB stage consumes: 256 steps per full circle, with sector equal to (6*h)>>8. A single shared 9-step restoring divider is reused for S and H, so there is no wide combinational divide.

---
 rtl/rgb_to_hsv_if.sv | 24 ++
 rtl/rgb_to_hsv.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rgb_to_hsv_if.sv
// Pixel-in / HSV-out handshake bundle for the RGB-to-HSV converter.
// master: pixel producer and result consumer; slave: the converter.
interface rgb_to_hsv_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] h;
    logic [7:0] s;
    logic [7:0] v;

    modport master (
        output in_valid, r, g, b, out_ready,
        input  in_ready, out_valid, h, s, v
    );

    modport slave (
        input  in_valid, r, g, b, out_ready,
        output in_ready, out_valid, h, s, v
    );
endinterface

// File: rtl/rgb_to_hsv.sv
// Iterative RGB-to-HSV converter, one shared 9-step restoring divider.
// Ports: clk, rst_n (async low), bus (slave: r/g/b in, h/s/v out).
module rgb_to_hsv (
    input  logic        clk,
    input  logic        rst_n,
    rgb_to_hsv_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, PREP, DIV_S, DIV_H, POST, OUT
    } state_t;

    state_t     state;
    logic [7:0] r_q, g_q, b_q;
    logic [7:0] mx, dlt, hnum;
    logic       neg;
    logic [2:0] dom;
    logic [8:0] rem;
    logic [7:0] den;
    logic [8:0] quo;
    logic [8:0] sq;
    logic [3:0] cnt;

    // PREP: max, min, dominant channel (ties r > g > b), hue sign and |diff|
    logic [7:0] p_max, p_min, p_abs;
    logic       p_neg;
    logic [2:0] p_dom;

    always_comb begin
        p_max = r_q;
        p_neg = 1'b0;
        p_abs = 8'd0;
        p_dom = 3'b001;
        if (r_q >= g_q && r_q >= b_q) begin
            p_dom = 3'b001;
            p_max = r_q;
            p_neg = g_q < b_q;
            p_abs = p_neg ? b_q - g_q : g_q - b_q;
        end else if (g_q >= b_q) begin
            p_dom = 3'b010;
            p_max = g_q;
            p_neg = b_q < r_q;
            p_abs = p_neg ? r_q - b_q : b_q - r_q;
        end else begin
            p_dom = 3'b100;
            p_max = b_q;
            p_neg = r_q < g_q;
            p_abs = p_neg ? g_q - r_q : r_q - g_q;
        end
        p_min = r_q;
        if (g_q < p_min) p_min = g_q;
        if (b_q < p_min) p_min = b_q;
    end

    // One restoring step. rem < 2*den always, so a successful subtract
    // leaves less than den and fits in 8 bits. den == 0 yields q = 0.
    logic       ge;
    logic [7:0] sub;
    logic [8:0] rem_nx;
    logic [8:0] quo_nx;

    always_comb begin
        ge     = (den != 8'd0) && (rem >= {1'b0, den});
        sub    = ge ? rem[7:0] - den : rem[7:0];
        rem_nx = {sub, 1'b0};
        quo_nx = {quo[7:0], ge};
    end

    // Linear hue from the hue quotient, then exact floor(lh/6) by
    // unrolled compare-subtract against 6<<i.
    logic [10:0] base;
    logic [10:0] lh;
    logic [10:0] rm;
    logic [7:0]  hq;

    always_comb begin
        unique case (1'b1)
            dom[0]:  base = neg ? 11'd1536 : 11'd0;
            dom[1]:  base = 11'd512;
            dom[2]:  base = 11'd1024;
            default: base = 11'd0;
        endcase
        lh = neg ? base - {2'b00, quo} : base + {2'b00, quo};
        if (lh == 11'd1536 || dlt == 8'd0) lh = 11'd0;
        rm = lh;
        hq = 8'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rm >= (11'd6 << i)) begin
                rm    = rm - (11'd6 << i);
                hq[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.h         <= 8'd0;
            bus.s         <= 8'd0;
            bus.v         <= 8'd0;
            r_q           <= 8'd0;
            g_q           <= 8'd0;
            b_q           <= 8'd0;
            mx            <= 8'd0;
            dlt           <= 8'd0;
            hnum          <= 8'd0;
            neg           <= 1'b0;
            dom           <= 3'd0;
            rem           <= 9'd0;
            den           <= 8'd0;
            quo           <= 9'd0;
            sq            <= 9'd0;
            cnt           <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_q          <= bus.r;
                        g_q          <= bus.g;
                        b_q          <= bus.b;
                        bus.in_ready <= 1'b0;
                        state        <= PREP;
                    end
                end
                PREP: begin
                    mx    <= p_max;
                    dlt   <= p_max - p_min;
                    hnum  <= p_abs;
                    neg   <= p_neg;
                    dom   <= p_dom;
                    rem   <= {1'b0, p_max - p_min};
                    den   <= p_max;
                    quo   <= 9'd0;
                    cnt   <= 4'd0;
                    state <= DIV_S;
                end
                DIV_S: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd8) begin
                        // Saturation done; reload divider for hue.
                        sq    <= quo_nx;
                        rem   <= {1'b0, hnum};
                        den   <= dlt;
                        quo   <= 9'd0;
                        cnt   <= 4'd0;
                        state <= DIV_H;
                    end
                end
                DIV_H: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd8) state <= POST;
                end
                POST: begin
                    bus.h         <= hq;
                    bus.s         <= sq[8] ? 8'd255 : sq[7:0];
                    bus.v         <= mx;
                    bus.out_valid <= 1'b1;
                    state         <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
